// File: rtl/seq_pkg.sv
// ============================================================================
// seq_pkg : shared types and widths for the serial "101" pattern generator
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam int MAX_LEN_DEF = 16;
    localparam int LEN_W       = $clog2(MAX_LEN_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } gen_state_t;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } trk_state_t;

endpackage

`default_nettype wire

// File: rtl/seq101_tracker.sv
// ============================================================================
// seq101_tracker : overlapping "101" recogniser over the generator's own output
// Rev 1.0
// ============================================================================
`default_nettype none

module seq101_tracker
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    input  logic bit_in,
    output logic hit
);

    trk_state_t state;
    trk_state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = S0;
        end else if (adv) begin
            case (state)
                S0:      state_nxt = bit_in ? S1   : S0;
                S1:      state_nxt = bit_in ? S1   : S10;
                S10:     state_nxt = bit_in ? S101 : S0;
                S101:    state_nxt = bit_in ? S1   : S10;
                default: state_nxt = S0;
            endcase
        end
    end

    // Flags the S101 entry in the same cycle so the counter lands on that edge
    assign hit = adv && !clr && (state == S10) && bit_in;

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
// ============================================================================
// seq_pattern_gen : repeats a pattern word MSB-first with idle gaps, and counts
//                   the overlapping "101" occurrences it puts on the line
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,   // LEN_W in seq_pkg is derived from MAX_LEN_DEF
    parameter int CNT_W   = 8,
    parameter int HIT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic [CNT_W-1:0]   reps,
    input  logic [CNT_W-1:0]   gap,
    output logic               out,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic [HIT_W-1:0]   exp_hits
);

    gen_state_t         state, state_nxt;
    logic [MAX_LEN-1:0] pat_al, shreg, shreg_nxt, pat_al_c;
    logic [LEN_W-1:0]   len_r, len_c, bit_cnt, bit_nxt;
    logic [CNT_W-1:0]   gap_r, gap_cnt, gap_nxt, rep_cnt, rep_nxt;
    logic               out_nxt, valid_nxt, busy_nxt, done_nxt;
    logic               load, clr, adv, hit;

    // Pattern is left-aligned at load so every bit leaves from the MSB
    assign len_c    = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    assign pat_al_c = pat << (LEN_W'(MAX_LEN) - len_c);

    always_comb begin
        state_nxt = state;
        out_nxt   = 1'b0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        rep_nxt   = rep_cnt;
        gap_nxt   = gap_cnt;
        load      = 1'b0;
        clr       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    clr  = 1'b1;
                    if ((len_c == '0) || (reps == '0)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                        out_nxt   = pat_al_c[MAX_LEN-1];
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                        shreg_nxt = pat_al_c << 1;
                        bit_nxt   = len_c - LEN_W'(1);
                        rep_nxt   = reps - CNT_W'(1);
                    end
                end
            end

            SHIFT: begin
                if (bit_cnt != '0) begin
                    out_nxt   = shreg[MAX_LEN-1];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    shreg_nxt = shreg << 1;
                    bit_nxt   = bit_cnt - LEN_W'(1);
                end else if ((rep_cnt != '0) && (gap_r != '0)) begin
                    state_nxt = GAP;
                    busy_nxt  = 1'b1;
                    gap_nxt   = gap_r - CNT_W'(1);
                end else if (rep_cnt != '0) begin
                    out_nxt   = pat_al[MAX_LEN-1];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    shreg_nxt = pat_al << 1;
                    bit_nxt   = len_r - LEN_W'(1);
                    rep_nxt   = rep_cnt - CNT_W'(1);
                end else begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end

            GAP: begin
                busy_nxt = 1'b1;
                if (gap_cnt == '0) begin
                    state_nxt = SHIFT;
                    out_nxt   = pat_al[MAX_LEN-1];
                    valid_nxt = 1'b1;
                    shreg_nxt = pat_al << 1;
                    bit_nxt   = len_r - LEN_W'(1);
                    rep_nxt   = rep_cnt - CNT_W'(1);
                end else begin
                    gap_nxt = gap_cnt - CNT_W'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            pat_al    <= '0;
            len_r     <= '0;
            gap_r     <= '0;
        end else begin
            state     <= state_nxt;
            out       <= out_nxt;
            out_valid <= valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_nxt;
            rep_cnt   <= rep_nxt;
            gap_cnt   <= gap_nxt;
            if (load) begin
                pat_al <= pat_al_c;
                len_r  <= len_c;
                gap_r  <= gap;
            end
        end
    end

    // Gap cycles drive 0 on the line, so they feed the tracker as zeros
    assign adv = (state == SHIFT) || (state == GAP);

    seq101_tracker u_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .adv    (adv),
        .bit_in (out),
        .hit    (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_hits <= '0;
        end else if (clr) begin
            exp_hits <= '0;
        end else if (hit && (exp_hits != '1)) begin
            exp_hits <= exp_hits + HIT_W'(1);
        end
    end

endmodule

`default_nettype wire
